// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter_pkg
//  Description : Shared BRAM geometry, arbiter state record and reset value
//                for the two-requester BRAM port A arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

    localparam int c_ADDR_W     = 10;
    localparam int c_DATA_W     = 16;
    localparam int c_BRAM_DEPTH = 1024;
    localparam int c_RD_LAT     = 1;
    localparam int c_MAX_LOCK   = 8;

    // Lock counter width; wide enough for any practical MAX_LOCK setting.
    localparam int c_LOCK_CNT_W = 8;

    // Requester identities: 0 is the control FSM, 1 is the display/debug scanner.
    typedef enum logic {
        REQ_FSM  = 1'b0,
        REQ_SCAN = 1'b1
    } req_id_t;

    // Registered arbitration state.
    typedef struct packed {
        req_id_t                 last_gnt;
        logic                    lock_vld;
        req_id_t                 lock_owner;
        logic [c_LOCK_CNT_W-1:0] lock_cnt;
    } arb_state_t;

    // last_gnt starts at 1 so requester 0 wins the first tie.
    localparam arb_state_t c_ARB_RESET = '{
        last_gnt:   REQ_SCAN,
        lock_vld:   1'b0,
        lock_owner: REQ_FSM,
        lock_cnt:   '0
    };

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter with burst lock and a lock-length
//                cap. Purely combinational: produces a one-hot grant and the
//                next arbitration state from requests, locks and current state.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import bram_port_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = c_MAX_LOCK
) (
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  arb_state_t i_state,
    output logic [1:0] o_gnt,
    output arb_state_t o_next
);

    localparam logic [c_LOCK_CNT_W-1:0] c_CAP = c_LOCK_CNT_W'(MAX_LOCK);

    logic                    w_owner_req;
    logic                    w_locked;
    logic                    w_cap_hit;
    logic                    w_xfer;
    logic                    w_other_wait;
    logic                    w_same_owner;
    req_id_t                 w_win;
    logic [c_LOCK_CNT_W-1:0] w_cnt_base;

    // Pick the winner, then derive last_gnt / lock owner / lock count updates.
    always_comb begin
        w_owner_req  = i_state.lock_vld & i_req[i_state.lock_owner];
        w_locked     = w_owner_req & (i_state.lock_cnt < c_CAP);
        // Owner still asking but has used its whole burst: ignore the lock once.
        w_cap_hit    = w_owner_req & ~w_locked;

        w_win = REQ_FSM;
        if (w_locked) begin
            w_win = i_state.lock_owner;
        end else if (i_req[0] & i_req[1]) begin
            w_win = (i_state.last_gnt == REQ_FSM) ? REQ_SCAN : REQ_FSM;
        end else if (i_req[1]) begin
            w_win = REQ_SCAN;
        end

        w_xfer       = |i_req;
        o_gnt        = w_xfer ? ((w_win == REQ_SCAN) ? 2'b10 : 2'b01) : 2'b00;
        w_other_wait = (w_win == REQ_FSM) ? i_req[1] : i_req[0];
        w_same_owner = i_state.lock_vld & (i_state.lock_owner == w_win);
        w_cnt_base   = w_same_owner ? i_state.lock_cnt : '0;

        o_next = i_state;
        if (w_xfer) begin
            o_next.last_gnt = w_win;
            if (i_lock[w_win]) begin
                o_next.lock_vld   = 1'b1;
                o_next.lock_owner = w_win;
                // Count only grants that made the other side wait.
                o_next.lock_cnt   = w_cap_hit ? '0
                                  : w_cnt_base + {{(c_LOCK_CNT_W-1){1'b0}}, w_other_wait};
            end else begin
                o_next.lock_vld   = 1'b0;
                o_next.lock_owner = REQ_FSM;
                o_next.lock_cnt   = '0;
            end
        end else if (i_state.lock_vld & ~w_owner_req) begin
            // Owner let go of its request: the lock is gone.
            o_next.lock_vld = 1'b0;
            o_next.lock_cnt = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter
//  Description : Shares BRAM port A between the control FSM (requester 0) and
//                the display/debug scanner (requester 1). Muxes the granted
//                requester onto the port, holds address/data while idle and
//                routes read data back through a tag pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int RD_LAT   = c_RD_LAT,
    parameter int MAX_LOCK = c_MAX_LOCK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] data_a,
    output logic              we_a,
    input  logic [DATA_W-1:0] q_a
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_xfer;
    logic              w_sel;
    logic [ADDR_W-1:0] w_mux_addr;
    logic [DATA_W-1:0] w_mux_data;
    logic              w_mux_we;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_data_hold;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_id;

    // Requests are masked during reset so no grant can escape.
    assign w_req = {req1, req0} & {2{~rst}};

    rr_arb2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .i_req   (w_req),
        .i_lock  ({lock1, lock0}),
        .i_state (r_state),
        .o_gnt   (w_gnt),
        .o_next  (w_next)
    );

    assign gnt0       = w_gnt[0];
    assign gnt1       = w_gnt[1];
    assign w_xfer     = |w_gnt;
    assign w_sel      = w_gnt[1];
    assign w_mux_addr = w_sel ? addr1  : addr0;
    assign w_mux_data = w_sel ? wdata1 : wdata0;
    assign w_mux_we   = w_sel ? we1    : we0;

    // Granted: pure mux of the requester. Idle: last driven values, no write.
    assign addr_a = w_xfer ? w_mux_addr : r_addr_hold;
    assign data_a = w_xfer ? w_mux_data : r_data_hold;
    assign we_a   = w_xfer & w_mux_we;

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ARB_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the port address/data on every transfer for the idle hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else if (w_xfer) begin
            r_addr_hold <= w_mux_addr;
            r_data_hold <= w_mux_data;
        end
    end

    // Read-tag pipeline matching the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_xfer & ~w_mux_we;
            r_tag_id[0]  <= w_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    // A read in flight when reset arrives must not report data.
    assign rvalid0 = ~rst & r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1];
    assign rvalid1 = ~rst & r_tag_vld[RD_LAT-1] &  r_tag_id[RD_LAT-1];
    assign rdata   = q_a;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_port_arbiter
//  Description : Self-checking bench for bram_port_arbiter: grant table,
//                directed corner sequences and a randomized run, all watched
//                by a reference model of the arbitration rules and a read
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;
    import bram_port_arbiter_pkg::*;

    localparam int AW  = c_ADDR_W;
    localparam int DW  = c_DATA_W;
    localparam int LAT = c_RD_LAT;
    localparam int ML  = c_MAX_LOCK;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, we_a;
    logic [DW-1:0] rdata, data_a, q_a;
    logic [AW-1:0] addr_a;

    int total = 0;
    int bad   = 0;

    bram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .addr_a(addr_a), .data_a(data_a), .we_a(we_a),
        .q_a(q_a)
    );

    always #5 clk = ~clk;

    // BRAM model (registered read, LAT = 1) and an independent reference copy.
    logic [DW-1:0] mem     [c_BRAM_DEPTH];
    logic [DW-1:0] ref_mem [c_BRAM_DEPTH];

    initial begin
        for (int i = 0; i < c_BRAM_DEPTH; i++) begin
            mem[i]     = 16'hA000 + 16'(i);
            ref_mem[i] = 16'hA000 + 16'(i);
        end
        mem[5]     = 16'hBEEF;
        ref_mem[5] = 16'hBEEF;
    end

    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        q_a <= mem[addr_a];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    int            cyc = 0;
    int            m_last = 1;
    int            m_owner = -1;
    int            m_cnt = 0;
    logic [AW-1:0] m_haddr = '0;
    logic [DW-1:0] m_hdata = '0;
    int            wait0 = 0, wait1 = 0;

    always @(negedge clk) begin : mon
        bit            rq[2];
        bit            lk[2];
        bit            capped;
        int            win;
        bit            erv0, erv1;
        logic [DW-1:0] erd;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        bit            wr;

        cyc++;
        erv0 = 1'b0; erv1 = 1'b0; erd = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (!rst) begin
                erv0 = (pend[0].id == 1'b0);
                erv1 = (pend[0].id == 1'b1);
                erd  = pend[0].data;
            end
            void'(pend.pop_front());
        end
        chk("mon_rvalid0", {31'd0, rvalid0}, {31'd0, erv0});
        chk("mon_rvalid1", {31'd0, rvalid1}, {31'd0, erv1});
        if (erv0 || erv1) chk("mon_rdata", {16'd0, rdata}, {16'd0, erd});

        if (rst) begin
            chk("mon_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            chk("mon_rst_we", {31'd0, we_a}, 32'd0);
            pend.delete();
            m_last = 1; m_owner = -1; m_cnt = 0;
            m_haddr = '0; m_hdata = '0;
            wait0 = 0; wait1 = 0;
        end else begin
            rq[0] = req0; rq[1] = req1;
            lk[0] = lock0; lk[1] = lock1;
            capped = (m_owner >= 0) && rq[m_owner] && (m_cnt >= ML);
            if ((m_owner >= 0) && rq[m_owner] && (m_cnt < ML)) win = m_owner;
            else if (rq[0] && rq[1]) win = 1 - m_last;
            else if (rq[0])          win = 0;
            else if (rq[1])          win = 1;
            else                     win = -1;

            chk("mon_gnt0", {31'd0, gnt0}, {31'd0, win == 0});
            chk("mon_gnt1", {31'd0, gnt1}, {31'd0, win == 1});

            if (win >= 0) begin
                ad = (win == 1) ? addr1  : addr0;
                wd = (win == 1) ? wdata1 : wdata0;
                wr = (win == 1) ? we1    : we0;
                chk("mon_addr_a", {22'd0, addr_a}, {22'd0, ad});
                chk("mon_we_a", {31'd0, we_a}, {31'd0, wr});
                if (wr) begin
                    chk("mon_data_a", {16'd0, data_a}, {16'd0, wd});
                    ref_mem[ad] = wd;
                end else begin
                    pend.push_back('{due: cyc + LAT, id: (win == 1), data: ref_mem[ad]});
                end
                m_haddr = ad; m_hdata = wd;
                m_last = win;
                if (lk[win]) begin
                    if (capped)             m_cnt = 0;
                    else if (m_owner == win) m_cnt = m_cnt + int'(rq[1-win]);
                    else                    m_cnt = int'(rq[1-win]);
                    m_owner = win;
                end else begin
                    m_owner = -1; m_cnt = 0;
                end
            end else begin
                chk("mon_idle_we", {31'd0, we_a}, 32'd0);
                chk("mon_idle_addr", {22'd0, addr_a}, {22'd0, m_haddr});
                chk("mon_idle_data", {16'd0, data_a}, {16'd0, m_hdata});
                m_owner = -1; m_cnt = 0;
            end

            wait0 = (rq[0] && win != 0) ? wait0 + 1 : 0;
            wait1 = (rq[1] && win != 1) ? wait1 + 1 : 0;
            if (wait0 > 0) chk("mon_wait0", {31'd0, wait0 <= ML + 1}, 32'd1);
            if (wait1 > 0) chk("mon_wait1", {31'd0, wait1 <= ML + 1}, 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit r0, r1, l0, l1, g0, g1;
    } vec_t;

    vec_t tbl[15];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit g0, g1;

        tbl[0]  = '{1,1,0,0, 1,0};
        tbl[1]  = '{1,1,0,0, 0,1};
        tbl[2]  = '{1,1,0,0, 1,0};
        tbl[3]  = '{0,1,0,0, 0,1};
        tbl[4]  = '{0,1,0,0, 0,1};
        tbl[5]  = '{1,0,0,0, 1,0};
        tbl[6]  = '{0,0,0,0, 0,0};
        tbl[7]  = '{1,1,0,0, 0,1};
        tbl[8]  = '{1,1,0,1, 1,0};
        tbl[9]  = '{1,1,0,1, 0,1};
        tbl[10] = '{1,1,0,1, 0,1};
        tbl[11] = '{1,0,1,0, 1,0};
        tbl[12] = '{1,1,1,0, 1,0};
        tbl[13] = '{1,1,0,0, 1,0};
        tbl[14] = '{1,1,0,0, 0,1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_addr_a", {22'd0, addr_a}, 32'd0);
        chk("rst_data_a", {16'd0, data_a}, 32'd0);
        chk("rst_we_a", {31'd0, we_a}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        step();

        // Grant table
        do_reset();
        addr0 = 10'd40; addr1 = 10'd41;
        for (int r = 0; r < 15; r++) begin
            req0 = tbl[r].r0; req1 = tbl[r].r1;
            lock0 = tbl[r].l0; lock1 = tbl[r].l1;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", r), {30'd0, gnt1, gnt0}, {30'd0, tbl[r].g1, tbl[r].g0});
            step();
        end
        idle_inputs();
        repeat (3) step();

        // T1 single read
        do_reset();
        req0 = 1'b1; addr0 = 10'd5;
        @(negedge clk);
        chk("t1_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        req0 = 1'b0;
        @(negedge clk);
        chk("t1_rvalid", {30'd0, rvalid1, rvalid0}, 32'd1);
        chk("t1_rdata", {16'd0, rdata}, 32'h0000BEEF);
        step();

        // T2 tie round-robin
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'd3; addr1 = 10'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t2_gnt%0d", k), {30'd0, gnt1, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) begin
                chk($sformatf("t2_rv%0d", k), {30'd0, rvalid1, rvalid0}, (k % 2 == 1) ? 32'd1 : 32'd2);
                chk($sformatf("t2_rd%0d", k), {16'd0, rdata}, (k % 2 == 1) ? 32'hA003 : 32'hA004);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("t2_rv_last", {30'd0, rvalid1, rvalid0}, 32'd2);
        chk("t2_rd_last", {16'd0, rdata}, 32'hA004);
        step();

        // T3 lock cap
        do_reset();
        req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; addr0 = 10'd6; addr1 = 10'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t3_gnt%0d", k), {30'd0, gnt1, gnt0}, (k == 8) ? 32'd2 : 32'd1);
            step();
        end
        idle_inputs();
        repeat (2) step();

        // T4 write then read
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd10; wdata0 = 16'h1234;
        @(negedge clk);
        chk("t4_wgnt", {30'd0, gnt1, gnt0}, 32'd1);
        chk("t4_we_a", {31'd0, we_a}, 32'd1);
        chk("t4_data_a", {16'd0, data_a}, 32'h1234);
        step();
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd10;
        @(negedge clk);
        chk("t4_rgnt", {30'd0, gnt1, gnt0}, 32'd2);
        step();
        req1 = 1'b0;
        @(negedge clk);
        chk("t4_rvalid", {30'd0, rvalid1, rvalid0}, 32'd2);
        chk("t4_rdata", {16'd0, rdata}, 32'h1234);
        step();

        // T5 reset mid-read
        do_reset();
        req0 = 1'b1; addr0 = 10'd5;
        @(negedge clk);
        chk("t5_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("t5_rv_in_rst", {30'd0, rvalid1, rvalid0}, 32'd0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rv_after", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("t5_addr_a", {22'd0, addr_a}, 32'd0);
        chk("t5_data_a", {16'd0, data_a}, 32'd0);
        step();
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'd3; addr1 = 10'd4;
        @(negedge clk);
        chk("t5_first_tie", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        idle_inputs();
        repeat (3) step();

        // T6 randomized run under the reference model
        g0 = 1'b1; g1 = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!req0 || g0) begin
                req0   = ($urandom_range(0, 3) != 0);
                we0    = $urandom_range(0, 1) == 1;
                addr0  = 10'd16 + 10'($urandom_range(0, 15));
                wdata0 = 16'($urandom);
            end
            if (!req1 || g1) begin
                req1   = ($urandom_range(0, 3) != 0);
                we1    = $urandom_range(0, 1) == 1;
                addr1  = 10'd16 + 10'($urandom_range(0, 15));
                wdata1 = 16'($urandom);
            end
            lock0 = ($urandom_range(0, 2) == 0);
            lock1 = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            step();
        end
        idle_inputs();
        repeat (LAT + 4) step();
        chk("t6_all_reads_returned", pend.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
